// File: rtl/stump_reg_scan_pkg.sv
// Shared definitions for the Stump register-bank debug scanner: default
// geometry of the bank and the scanner state encoding. The host-side debug
// block decodes the same state values, so the encodings are fixed here.
package stump_reg_scan_pkg;

   localparam int SCAN_NUM_REGS = 8;
   localparam int SCAN_ADDR_W   = 3;
   localparam int SCAN_DATA_W   = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_SEND = 2'd2
   } scan_state_t;

endpackage

// File: rtl/stump_reg_scan.sv
// Debug reader for the Stump register bank's observability port C.
// Walks read_addr_C over the bank (full dump or a single register), samples
// each register during its own LOAD cycle and streams (addr, data) beats to
// the debug host over a valid/ready interface. The execution ports are never
// touched and the bank is never written.
module stump_reg_scan
   import stump_reg_scan_pkg::*;
#(
   parameter int NUM_REGS = SCAN_NUM_REGS,
   parameter int ADDR_W   = SCAN_ADDR_W,
   parameter int DATA_W   = SCAN_DATA_W,
   parameter int SKIP_R0  = 0
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              scan_req,
   input  logic              single_req,
   input  logic [ADDR_W-1:0] single_addr,
   input  logic              abort,
   output logic              busy,
   output logic [ADDR_W-1:0] reg_addr_C,
   input  logic [DATA_W-1:0] reg_data_C,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] out_addr,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic              done
);

   // First register of a full dump: r0 is hard-wired zero, so it may be skipped.
   localparam logic [ADDR_W-1:0] DUMP_FIRST = (SKIP_R0 != 0) ? ADDR_W'(1) : ADDR_W'(0);
   localparam logic [ADDR_W-1:0] DUMP_LAST  = ADDR_W'(NUM_REGS - 1);

   scan_state_t       state;
   scan_state_t       state_next;
   logic [ADDR_W-1:0] idx;
   logic [ADDR_W-1:0] last_idx;
   logic              single_ok;
   logic              start_scan;
   logic              start_single;
   logic              capture;
   logic              accept;
   logic              aborting;

   // A single read of a register that does not exist is dropped.
   assign single_ok = ({1'b0, single_addr} < (ADDR_W + 1)'(NUM_REGS));

   // idx only changes on the way into LOAD, so it doubles as the port-C
   // address: it equals idx during LOAD and holds its last value elsewhere.
   assign reg_addr_C = idx;
   assign busy       = (state != ST_IDLE);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state decode and the control strobes that drive the datapath.
   // abort outranks acceptance, and scan_req outranks single_req.
   always_comb begin
      state_next   = state;
      start_scan   = 1'b0;
      start_single = 1'b0;
      capture      = 1'b0;
      accept       = 1'b0;
      aborting     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (scan_req) begin
               start_scan = 1'b1;
               state_next = ST_LOAD;
            end else if (single_req && single_ok) begin
               start_single = 1'b1;
               state_next   = ST_LOAD;
            end
         end
         ST_LOAD: begin
            if (abort) begin
               aborting   = 1'b1;
               state_next = ST_IDLE;
            end else begin
               capture    = 1'b1;
               state_next = ST_SEND;
            end
         end
         ST_SEND: begin
            if (abort) begin
               aborting   = 1'b1;
               state_next = ST_IDLE;
            end else if (out_valid && out_ready) begin
               accept     = 1'b1;
               state_next = out_last ? ST_IDLE : ST_LOAD;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Scan index, beat register and done pulse. The beat is captured once in
   // LOAD and then held untouched until the host takes it or the scan aborts.
   always_ff @(posedge clk) begin
      if (rst) begin
         idx       <= '0;
         last_idx  <= '0;
         out_valid <= 1'b0;
         out_addr  <= '0;
         out_data  <= '0;
         out_last  <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start_scan) begin
            idx      <= DUMP_FIRST;
            last_idx <= DUMP_LAST;
         end
         if (start_single) begin
            idx      <= single_addr;
            last_idx <= single_addr;
         end
         if (capture) begin
            out_data  <= reg_data_C;
            out_addr  <= idx;
            out_last  <= (idx == last_idx);
            out_valid <= 1'b1;
         end
         if (aborting) begin
            out_valid <= 1'b0;
         end
         if (accept) begin
            out_valid <= 1'b0;
            if (out_last) begin
               done <= 1'b1;
            end else begin
               idx <= idx + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_stump_reg_scan.sv
// Self-checking bench for stump_reg_scan. A behavioural register bank feeds
// port C of two scanners (r0 kept, r0 skipped); expected beat lists are built
// from the bank contents and the dump/single-read rules.
module tb_stump_reg_scan;

   localparam int NR = 8;
   localparam int AW = 3;
   localparam int DW = 16;

   logic clk = 1'b0;
   logic rst;
   logic scan_req, single_req, abort, out_ready, scan_req1;
   logic [AW-1:0] single_addr;
   logic [DW-1:0] bank [NR];

   logic          busy0, valid0, last0, done0;
   logic [AW-1:0] addr_c0, oaddr0;
   logic [DW-1:0] data_c0, odata0;
   logic          busy1, valid1, last1, done1;
   logic [AW-1:0] addr_c1, oaddr1;
   logic [DW-1:0] data_c1, odata1;

   int compares;
   int mismatches;

   logic [AW-1:0] got_addr [$];
   logic [DW-1:0] got_data [$];
   logic          got_last [$];
   int            got_cyc  [$];
   int            done_count;
   int            done_stray;
   bit            timed_out;

   always #5 clk = ~clk;

   // Bank model: combinational read, r0 forced to zero.
   assign data_c0 = (addr_c0 == '0) ? '0 : bank[addr_c0];
   assign data_c1 = (addr_c1 == '0) ? '0 : bank[addr_c1];

   stump_reg_scan #(.NUM_REGS(NR), .ADDR_W(AW), .DATA_W(DW), .SKIP_R0(0)) dut0 (
      .clk(clk), .rst(rst), .scan_req(scan_req), .single_req(single_req),
      .single_addr(single_addr), .abort(abort), .busy(busy0),
      .reg_addr_C(addr_c0), .reg_data_C(data_c0), .out_valid(valid0),
      .out_ready(out_ready), .out_addr(oaddr0), .out_data(odata0),
      .out_last(last0), .done(done0)
   );

   stump_reg_scan #(.NUM_REGS(NR), .ADDR_W(AW), .DATA_W(DW), .SKIP_R0(1)) dut1 (
      .clk(clk), .rst(rst), .scan_req(scan_req1), .single_req(1'b0),
      .single_addr(single_addr), .abort(1'b0), .busy(busy1),
      .reg_addr_C(addr_c1), .reg_data_C(data_c1), .out_valid(valid1),
      .out_ready(out_ready), .out_addr(oaddr1), .out_data(odata1),
      .out_last(last1), .done(done1)
   );

   // Records accepted beats from one scanner until the last beat is taken.
   task automatic collect(input int which, input int max_cycles, input int ready_pct);
      bit            acc;
      logic          v, l, dn;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      got_addr.delete(); got_data.delete(); got_last.delete(); got_cyc.delete();
      done_count = 0; done_stray = 0; timed_out = 1'b1;
      for (int c = 0; c < max_cycles; c++) begin
         out_ready = (int'($urandom_range(99)) < ready_pct);
         v = (which != 0) ? valid1 : valid0;
         a = (which != 0) ? oaddr1 : oaddr0;
         d = (which != 0) ? odata1 : odata0;
         l = (which != 0) ? last1  : last0;
         acc = v && out_ready;
         if (acc) begin
            got_addr.push_back(a); got_data.push_back(d);
            got_last.push_back(l); got_cyc.push_back(c);
         end
         @(posedge clk); #1;
         dn = (which != 0) ? done1 : done0;
         if (dn) begin
            done_count++;
            if (!(acc && l)) done_stray++;
         end
         if (acc && l) begin
            timed_out = 1'b0;
            break;
         end
      end
   endtask

   task automatic test_reset();
      scan_req = 0; single_req = 0; abort = 0; out_ready = 0; scan_req1 = 0;
      single_addr = '0;
      rst = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      compares++;
      if ({busy0, addr_c0, valid0, oaddr0, odata0, last0, done0} !== '0) begin
         mismatches++;
         $display("[TB] FAIL reset_dut0: got %h want 0", {busy0, addr_c0, valid0, oaddr0, odata0, last0, done0});
      end
      compares++;
      if ({busy1, addr_c1, valid1, oaddr1, odata1, last1, done1} !== '0) begin
         mismatches++;
         $display("[TB] FAIL reset_dut1: got %h want 0", {busy1, addr_c1, valid1, oaddr1, odata1, last1, done1});
      end
      rst = 1'b0;
      @(posedge clk); #1;
      compares++;
      if (busy0 !== 1'b0 || valid0 !== 1'b0) begin
         mismatches++;
         $display("[TB] FAIL idle_after_reset: got busy=%b valid=%b want 0 0", busy0, valid0);
      end
   endtask

   task automatic test_full_dump();
      for (int i = 0; i < NR; i++) bank[i] = 16'(i * 16'h1111);
      out_ready = 1'b1;
      scan_req = 1'b1; @(posedge clk); #1; scan_req = 1'b0;
      compares++;
      if (busy0 !== 1'b1 || valid0 !== 1'b0) begin
         mismatches++;
         $display("[TB] FAIL dump_load_cycle: got busy=%b valid=%b want 1 0", busy0, valid0);
      end
      collect(0, 60, 100);
      compares++;
      if (timed_out || got_addr.size() != NR) begin
         mismatches++;
         $display("[TB] FAIL dump_count: got %0d beats (timeout=%0d) want %0d", got_addr.size(), timed_out, NR);
      end else begin
         compares++;
         if (got_cyc[0] != 1) begin
            mismatches++;
            $display("[TB] FAIL dump_latency: got first beat at cycle %0d want 1", got_cyc[0]);
         end
         for (int i = 0; i < NR; i++) begin
            compares++;
            if ({got_addr[i], got_data[i], got_last[i]} !== {AW'(i), 16'(i * 16'h1111), (i == NR - 1)}) begin
               mismatches++;
               $display("[TB] FAIL dump_beat%0d: got %h/%h/%b want %h/%h/%b", i, got_addr[i], got_data[i],
                        got_last[i], AW'(i), 16'(i * 16'h1111), (i == NR - 1));
            end
            if (i > 0) begin
               compares++;
               if (got_cyc[i] - got_cyc[i-1] != 2) begin
                  mismatches++;
                  $display("[TB] FAIL dump_rate%0d: got spacing %0d want 2", i, got_cyc[i] - got_cyc[i-1]);
               end
            end
         end
      end
      compares++;
      if (done_count != 1 || done_stray != 0 || busy0 !== 1'b0) begin
         mismatches++;
         $display("[TB] FAIL dump_done: got done=%0d stray=%0d busy=%b want 1 0 0", done_count, done_stray, busy0);
      end
      @(posedge clk); #1;
      compares++;
      if (done0 !== 1'b0) begin
         mismatches++;
         $display("[TB] FAIL dump_done_width: got done=%b want 0", done0);
      end
   endtask

   task automatic test_skip_r0();
      out_ready = 1'b1;
      scan_req1 = 1'b1; @(posedge clk); #1; scan_req1 = 1'b0;
      collect(1, 60, 100);
      compares++;
      if (timed_out || got_addr.size() != NR - 1) begin
         mismatches++;
         $display("[TB] FAIL skip_count: got %0d beats want %0d", got_addr.size(), NR - 1);
      end else begin
         for (int i = 0; i < NR - 1; i++) begin
            compares++;
            if ({got_addr[i], got_data[i], got_last[i]} !== {AW'(i + 1), 16'((i + 1) * 16'h1111), (i == NR - 2)}) begin
               mismatches++;
               $display("[TB] FAIL skip_beat%0d: got %h/%h/%b want %h/%h/%b", i, got_addr[i], got_data[i],
                        got_last[i], AW'(i + 1), 16'((i + 1) * 16'h1111), (i == NR - 2));
            end
         end
      end
      compares++;
      if (done_count != 1 || done_stray != 0) begin
         mismatches++;
         $display("[TB] FAIL skip_done: got %0d/%0d want 1/0", done_count, done_stray);
      end
   endtask

   task automatic test_single();
      logic [AW-1:0] a;
      bank[7] = 16'h0C4A;
      for (int n = 0; n < 5; n++) begin
         if (n == 0)      a = AW'(5);
         else if (n == 1) a = AW'(7);
         else begin
            a = AW'($urandom_range(NR - 1));
            for (int i = 1; i < NR; i++) bank[i] = 16'($urandom);
         end
         single_addr = a;
         single_req = 1'b1; @(posedge clk); #1; single_req = 1'b0;
         collect(0, 40, (n < 2) ? 100 : 50);
         compares++;
         if (timed_out || got_addr.size() != 1) begin
            mismatches++;
            $display("[TB] FAIL single%0d_count: got %0d beats want 1", n, got_addr.size());
         end else begin
            compares++;
            if ({got_addr[0], got_data[0], got_last[0]} !== {a, ((a == 0) ? 16'h0 : bank[a]), 1'b1}) begin
               mismatches++;
               $display("[TB] FAIL single%0d_beat: got %h/%h/%b want %h/%h/1", n, got_addr[0], got_data[0],
                        got_last[0], a, ((a == 0) ? 16'h0 : bank[a]));
            end
         end
         compares++;
         if (done_count != 1 || done_stray != 0) begin
            mismatches++;
            $display("[TB] FAIL single%0d_done: got %0d/%0d want 1/0", n, done_count, done_stray);
         end
      end
   endtask

   task automatic test_backpressure();
      bit found;
      for (int i = 1; i < NR; i++) bank[i] = 16'($urandom);
      out_ready = 1'b1;
      scan_req = 1'b1; @(posedge clk); #1; scan_req = 1'b0;
      found = 1'b0;
      for (int c = 0; c < 40; c++) begin
         if (valid0 && oaddr0 == AW'(3)) begin
            found = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      out_ready = 1'b0;
      compares++;
      if (!found) begin
         mismatches++;
         $display("[TB] FAIL stall_reach: got no beat 3 want beat 3");
      end
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         compares++;
         if ({valid0, oaddr0, odata0, last0, addr_c0} !== {1'b1, AW'(3), bank[3], 1'b0, AW'(3)}) begin
            mismatches++;
            $display("[TB] FAIL stall_hold%0d: got %h want %h", c, {valid0, oaddr0, odata0, last0, addr_c0},
                     {1'b1, AW'(3), bank[3], 1'b0, AW'(3)});
         end
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      collect(0, 40, 100);
      compares++;
      if (timed_out || got_addr.size() != 4) begin
         mismatches++;
         $display("[TB] FAIL stall_rest: got %0d beats want 4", got_addr.size());
      end else begin
         compares++;
         if ({got_addr[0], got_data[0]} !== {AW'(4), bank[4]}) begin
            mismatches++;
            $display("[TB] FAIL stall_next: got %h/%h want 4/%h", got_addr[0], got_data[0], bank[4]);
         end
      end
   endtask

   task automatic test_abort();
      bit found;
      bit bad;
      out_ready = 1'b1;
      scan_req = 1'b1; @(posedge clk); #1; scan_req = 1'b0;
      found = 1'b0;
      for (int c = 0; c < 40; c++) begin
         if (valid0 && oaddr0 == AW'(2)) begin
            found = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      compares++;
      if (!found || valid0 !== 1'b0 || busy0 !== 1'b0 || done0 !== 1'b0) begin
         mismatches++;
         $display("[TB] FAIL abort_stop: got found=%0d valid=%b busy=%b done=%b want 1 0 0 0", found, valid0, busy0, done0);
      end
      bad = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #1;
         if (valid0 !== 1'b0 || done0 !== 1'b0) bad = 1'b1;
      end
      compares++;
      if (bad) begin
         mismatches++;
         $display("[TB] FAIL abort_quiet: got activity after abort want none");
      end
      abort = 1'b1; scan_req = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0; scan_req = 1'b0;
      collect(0, 80, 70);
      compares++;
      if (timed_out || got_addr.size() != NR || got_addr[0] !== AW'(0)) begin
         mismatches++;
         $display("[TB] FAIL abort_restart: got %0d beats want %0d from addr 0", got_addr.size(), NR);
      end
   endtask

   task automatic test_both_req();
      out_ready = 1'b1;
      single_addr = AW'(4);
      scan_req = 1'b1; single_req = 1'b1;
      @(posedge clk); #1;
      scan_req = 1'b0; single_req = 1'b0;
      collect(0, 60, 100);
      compares++;
      if (timed_out || got_addr.size() != NR || got_addr[0] !== AW'(0)) begin
         mismatches++;
         $display("[TB] FAIL both_req: got %0d beats want %0d from addr 0", got_addr.size(), NR);
      end
   endtask

   task automatic test_reset_mid();
      bit bad;
      out_ready = 1'b1;
      scan_req = 1'b1; @(posedge clk); #1; scan_req = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      compares++;
      if ({busy0, addr_c0, valid0, oaddr0, odata0, last0, done0} !== '0) begin
         mismatches++;
         $display("[TB] FAIL reset_mid: got %h want 0", {busy0, addr_c0, valid0, oaddr0, odata0, last0, done0});
      end
      bad = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); #1;
         if (valid0 !== 1'b0 || done0 !== 1'b0 || busy0 !== 1'b0) bad = 1'b1;
      end
      compares++;
      if (bad) begin
         mismatches++;
         $display("[TB] FAIL reset_mid_quiet: got activity after reset want none");
      end
   endtask

   task automatic test_coherency();
      bit found;
      for (int i = 1; i < NR; i++) bank[i] = 16'($urandom);
      bank[1] = 16'h1234;
      out_ready = 1'b1;
      scan_req = 1'b1; @(posedge clk); #1; scan_req = 1'b0;
      found = 1'b0;
      for (int c = 0; c < 40; c++) begin
         if (valid0 && oaddr0 == AW'(1)) begin
            found = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      out_ready = 1'b0;
      bank[1] = 16'hDEAD;
      bank[2] = 16'hABCD;
      @(posedge clk); #1;
      collect(0, 60, 100);
      compares++;
      if (!found || timed_out || got_addr.size() != NR - 1) begin
         mismatches++;
         $display("[TB] FAIL coh_count: got %0d beats want %0d", got_addr.size(), NR - 1);
      end else begin
         compares++;
         if ({got_data[0], got_data[1]} !== {16'h1234, 16'hABCD}) begin
            mismatches++;
            $display("[TB] FAIL coh_data: got %h/%h want 1234/abcd", got_data[0], got_data[1]);
         end
      end
   endtask

   task automatic test_random();
      logic [AW-1:0] exp_addr [$];
      logic [AW-1:0] a;
      bit            is_scan;
      for (int n = 0; n < 6; n++) begin
         for (int i = 1; i < NR; i++) bank[i] = 16'($urandom);
         is_scan = ($urandom_range(1) == 1);
         a = AW'($urandom_range(NR - 1));
         exp_addr.delete();
         if (is_scan) begin
            for (int i = 0; i < NR; i++) exp_addr.push_back(AW'(i));
         end else begin
            exp_addr.push_back(a);
         end
         single_addr = a;
         scan_req = is_scan; single_req = !is_scan;
         @(posedge clk); #1;
         scan_req = 1'b0; single_req = 1'b0;
         collect(0, 200, int'($urandom_range(100, 30)));
         compares++;
         if (timed_out || got_addr.size() != exp_addr.size()) begin
            mismatches++;
            $display("[TB] FAIL rand%0d_count: got %0d beats want %0d", n, got_addr.size(), exp_addr.size());
         end else begin
            for (int i = 0; i < exp_addr.size(); i++) begin
               compares++;
               if ({got_addr[i], got_data[i], got_last[i]} !==
                   {exp_addr[i], ((exp_addr[i] == 0) ? 16'h0 : bank[exp_addr[i]]), (i == exp_addr.size() - 1)}) begin
                  mismatches++;
                  $display("[TB] FAIL rand%0d_beat%0d: got %h/%h/%b want %h/%h", n, i, got_addr[i], got_data[i],
                           got_last[i], exp_addr[i], ((exp_addr[i] == 0) ? 16'h0 : bank[exp_addr[i]]));
               end
            end
         end
         compares++;
         if (done_count != 1 || done_stray != 0) begin
            mismatches++;
            $display("[TB] FAIL rand%0d_done: got %0d/%0d want 1/0", n, done_count, done_stray);
         end
      end
   endtask

   initial begin
      compares = 0;
      mismatches = 0;
      for (int i = 0; i < NR; i++) bank[i] = '0;
      test_reset();
      test_full_dump();
      test_skip_r0();
      test_single();
      test_backpressure();
      test_abort();
      test_both_req();
      test_reset_mid();
      test_coherency();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, mismatches);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got no finish want finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
